// File: rtl/color_mix_fade.sv
// -----------------------------------------------------------------------------
// color_mix_fade
//
// Video-path colour/monochrome mixer with a frame-synchronous fade envelope.
// RGB is converted to luma and tinted (green, amber, blue, grey) or passed
// through as colour, then scaled by a fade level that steps once every
// FADE_DIV VSync rising edges toward black (fade_out=1) or full (fade_out=0).
//
// Optional feature macro: COLOR_MIX_FADE_EN
//   defined     -> fade FSM, frame counter and stage-3 multiplier are built
//   not defined -> stage 3 is a plain register, fade_out is ignored,
//                  fade_level = LMAX, fade_busy = 0
//
// Parameters:
//   DW        component width (4..10)
//   FW        fade level width, 2^FW levels
//   FADE_DIV  frames per fade step (1..255)
//
// Ports:
//   clk_vid                 video clock
//   reset_n                 asynchronous active-low reset
//   ce_pix                  pixel enable, pipeline advances only when 1
//   mono[2:0]               0 colour, 1 green, 2 amber, 3 blue, 4..7 grey
//   R_in/G_in/B_in          input colour
//   HSync_in..VBlank_in     input timing
//   fade_out                1 = fade toward black, 0 = fade toward full
//   R_out/G_out/B_out       output colour, 3 ce_pix pulses after input
//   HSync_out..VBlank_out   timing, delay-matched to the colour outputs
//   fade_level[FW-1:0]      current fade level
//   fade_busy               high while fading down or up
// -----------------------------------------------------------------------------
module color_mix_fade #(
  parameter int DW       = 8,
  parameter int FW       = 4,
  parameter int FADE_DIV = 1
) (
  input  logic          clk_vid,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic [2:0]    mono,
  input  logic [DW-1:0] R_in,
  input  logic [DW-1:0] G_in,
  input  logic [DW-1:0] B_in,
  input  logic          HSync_in,
  input  logic          VSync_in,
  input  logic          HBlank_in,
  input  logic          VBlank_in,
  input  logic          fade_out,
  output logic [DW-1:0] R_out,
  output logic [DW-1:0] G_out,
  output logic [DW-1:0] B_out,
  output logic          HSync_out,
  output logic          VSync_out,
  output logic          HBlank_out,
  output logic          VBlank_out,
  output logic [FW-1:0] fade_level,
  output logic          fade_busy
);

  localparam int            PW   = DW + 8;       // luma product / sum width
  localparam logic [FW-1:0] LMAX = '1;

  genvar gi;

  // Channel index 0 = R, 1 = G, 2 = B throughout.
  logic [DW-1:0] rgb_in      [3];
  logic [PW-1:0] prod_next   [3];
  logic [DW-1:0] s1_rgb_reg  [3];
  logic [PW-1:0] s1_prod_reg [3];
  logic [DW-1:0] s2_rgb_next [3];
  logic [DW-1:0] s2_rgb_reg  [3];
  logic [DW-1:0] s3_rgb_next [3];
  logic [DW-1:0] s3_rgb_reg  [3];

  // Timing bits packed as {HSync, VSync, HBlank, VBlank}.
  logic [3:0] s1_sync_reg, s2_sync_reg, s3_sync_reg;

  assign rgb_in[0] = R_in;
  assign rgb_in[1] = G_in;
  assign rgb_in[2] = B_in;

  // ---------------------------------------------------------------------------
  // Stage 1 products: luma weights 54/183/18 sum to 255, so the three
  // products added together always fit in DW+8 bits.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 3; gi++) begin : g_prod
      localparam logic [PW-1:0] COEF = (gi == 0) ? PW'(54) :
                                       (gi == 1) ? PW'(183) : PW'(18);
      assign prod_next[gi] = PW'(rgb_in[gi]) * COEF;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 2: luma and tint select
  // ---------------------------------------------------------------------------
  logic [PW-1:0] luma_sum;
  logic [DW-1:0] luma;
  logic [7:0]    luma_frac_unused;
  logic [DW-1:0] amber_g;

  assign luma_sum                 = s1_prod_reg[0] + s1_prod_reg[1] + s1_prod_reg[2];
  assign {luma, luma_frac_unused} = luma_sum;
  assign amber_g                  = luma - (luma >> 2);

  always_comb begin
    s2_rgb_next = '{default: '0};
    case (mono)
      3'd0: s2_rgb_next = s1_rgb_reg;
      3'd1: s2_rgb_next[1] = luma;
      3'd2: begin
        s2_rgb_next[0] = luma;
        s2_rgb_next[1] = amber_g;
      end
      3'd3: s2_rgb_next[2] = luma;
      default: begin
        s2_rgb_next[0] = luma;
        s2_rgb_next[1] = luma;
        s2_rgb_next[2] = luma;
      end
    endcase
  end

`ifdef COLOR_MIX_FADE_EN
  // ---------------------------------------------------------------------------
  // Fade FSM: level changes only on counted VSync edges, so it is constant
  // within a frame. A direction change takes priority over a step.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_FULL  = 2'd0,
    ST_DOWN  = 2'd1,
    ST_BLACK = 2'd2,
    ST_UP    = 2'd3
  } fade_state_t;

  fade_state_t   state_reg, state_next;
  logic [FW-1:0] level_reg, level_next;
  logic [7:0]    frame_cnt_reg, frame_cnt_next;
  logic          vs_prev_reg;
  logic          vs_edge;
  logic          frame_done;

  assign vs_edge    = ce_pix & VSync_in & ~vs_prev_reg;
  assign frame_done = (frame_cnt_reg == 8'(FADE_DIV - 1));

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_FULL;
      level_reg     <= LMAX;
      frame_cnt_reg <= '0;
      vs_prev_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      level_reg     <= level_next;
      frame_cnt_reg <= frame_cnt_next;
      if (ce_pix) begin
        vs_prev_reg <= VSync_in;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    level_next     = level_reg;
    frame_cnt_next = frame_cnt_reg;
    case (state_reg)
      ST_FULL: begin
        if (fade_out) begin
          state_next     = ST_DOWN;
          frame_cnt_next = '0;
        end
      end
      ST_DOWN: begin
        if (!fade_out) begin
          state_next     = ST_UP;
          frame_cnt_next = '0;
        end else if (level_reg == '0) begin
          // Reached when UP reversed at level 0; nothing left to step.
          state_next     = ST_BLACK;
          frame_cnt_next = '0;
        end else if (vs_edge) begin
          if (frame_done) begin
            level_next     = level_reg - 1'b1;
            frame_cnt_next = '0;
            if (level_reg == FW'(1)) begin
              state_next = ST_BLACK;
            end
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
      end
      ST_BLACK: begin
        if (!fade_out) begin
          state_next     = ST_UP;
          frame_cnt_next = '0;
        end
      end
      ST_UP: begin
        if (fade_out) begin
          state_next     = ST_DOWN;
          frame_cnt_next = '0;
        end else if (level_reg == LMAX) begin
          state_next     = ST_FULL;
          frame_cnt_next = '0;
        end else if (vs_edge) begin
          if (frame_done) begin
            level_next     = level_reg + 1'b1;
            frame_cnt_next = '0;
            if (level_reg == LMAX - FW'(1)) begin
              state_next = ST_FULL;
            end
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next     = ST_FULL;
        level_next     = LMAX;
        frame_cnt_next = '0;
      end
    endcase
  end

  assign fade_level = level_reg;
  assign fade_busy  = (state_reg == ST_DOWN) || (state_reg == ST_UP);

  // ---------------------------------------------------------------------------
  // Stage 3 fade multiply: (c*(L+1)) >> FW, forced to 0 at L = 0.
  // The product never exceeds c << FW, so its top bit is always 0.
  // ---------------------------------------------------------------------------
  localparam int MW = DW + FW + 1;

  logic [FW:0] level_p1;
  assign level_p1 = {1'b0, level_reg} + (FW+1)'(1);

  generate
    for (gi = 0; gi < 3; gi++) begin : g_fade
      logic [MW-1:0] prod;
      logic          prod_top_unused;
      logic [DW-1:0] scaled;
      logic [FW-1:0] prod_frac_unused;

      assign prod = MW'(s2_rgb_reg[gi]) * MW'(level_p1);
      assign {prod_top_unused, scaled, prod_frac_unused} = prod;
      assign s3_rgb_next[gi] = (level_reg == '0) ? '0 : scaled;
    end
  endgenerate
`else
  logic fade_out_unused;
  assign fade_out_unused = fade_out;
  assign fade_level      = LMAX;
  assign fade_busy       = 1'b0;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_pass
      assign s3_rgb_next[gi] = s2_rgb_reg[gi];
    end
  endgenerate
`endif

  // ---------------------------------------------------------------------------
  // Pipeline registers, all qualified by ce_pix
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      s1_rgb_reg  <= '{default: '0};
      s1_prod_reg <= '{default: '0};
      s2_rgb_reg  <= '{default: '0};
      s3_rgb_reg  <= '{default: '0};
      s1_sync_reg <= '0;
      s2_sync_reg <= '0;
      s3_sync_reg <= '0;
    end else if (ce_pix) begin
      s1_rgb_reg  <= rgb_in;
      s1_prod_reg <= prod_next;
      s2_rgb_reg  <= s2_rgb_next;
      s3_rgb_reg  <= s3_rgb_next;
      s1_sync_reg <= {HSync_in, VSync_in, HBlank_in, VBlank_in};
      s2_sync_reg <= s1_sync_reg;
      s3_sync_reg <= s2_sync_reg;
    end
  end

  assign R_out      = s3_rgb_reg[0];
  assign G_out      = s3_rgb_reg[1];
  assign B_out      = s3_rgb_reg[2];
  assign HSync_out  = s3_sync_reg[3];
  assign VSync_out  = s3_sync_reg[2];
  assign HBlank_out = s3_sync_reg[1];
  assign VBlank_out = s3_sync_reg[0];

endmodule

// File: doc/color_mix_fade.md
# color_mix_fade

Parametrised successor to the fixed 8-bit colour/monochrome mixer in the video output path. Converts RGB to a selectable monochrome tint (green, amber, blue, grey) or passes colour through, then applies a frame-synchronous fade-to-black/fade-in envelope. The block sits between the core's video generator and the scaler/OSD, on `clk_vid` qualified by `ce_pix`.

## Interface
Parameters:
- `DW`, 8, component width, legal range 4..10.
- `FW`, 4, fade level width; there are 2^FW levels.
- `FADE_DIV`, 1, frames per fade step, legal range 1..255.

Ports:
- `clk_vid`  in  1  video clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce_pix`  in  1  pixel enable; the pipeline advances only when it is 1.
- `mono`  in  3  0 colour, 1 green, 2 amber, 3 blue, 4..7 grey.
- `R_in`, `G_in`, `B_in`  in  DW  input colour.
- `HSync_in`, `VSync_in`, `HBlank_in`, `VBlank_in`  in  1  input timing.
- `fade_out`  in  1  level-sensitive: 1 = fade toward black, 0 = fade toward full.
- `R_out`, `G_out`, `B_out`  out  DW  output colour.
- `HSync_out`, `VSync_out`, `HBlank_out`, `VBlank_out`  out  1  timing, delay-matched to the colour outputs.
- `fade_level`  out  FW  current level; LMAX = 2^FW-1.
- `fade_busy`  out  1  high while the FSM is in DOWN or UP.

## Operation
- Luma: Y = (54·R + 183·G + 18·B) >> 8.
  - Products are DW+8 bits wide; the sum is DW+8 bits and cannot overflow.
  - Y is DW bits.
  - All-ones white gives 2^DW-2 (254 at DW=8).
- Mode select:
  - 0: outputs equal the inputs.
  - 1: (0, Y, 0).
  - 2: (Y, Y − (Y>>2), 0).
  - 3: (0, 0, Y).
  - 4..7: (Y, Y, Y).
- Fade scaling per component c:
  - L = 0 gives 0.
  - Otherwise the output is (c·(L+1)) >> FW.
  - L = LMAX therefore passes c unchanged.
- Fade FSM states: FULL (L = LMAX), DOWN, BLACK (L = 0), UP.
  - A step event is the FADE_DIV-th VSync_in rising edge, counted by a frame counter that is cleared on every state entry. The edge is sampled on ce_pix cycles.
  - FULL: `fade_out`=1 moves to DOWN.
  - DOWN: each step sets L−1. L reaching 0 moves to BLACK. `fade_out`=0 moves to UP immediately, keeping the current L.
  - BLACK: `fade_out`=0 moves to UP.
  - UP: each step sets L+1. L reaching LMAX moves to FULL. `fade_out`=1 moves to DOWN immediately, keeping the current L.
- `fade_out` is evaluated every clock. A step event and a direction change in the same cycle: the direction change wins and no step is taken that cycle.
- Reset mid-fade returns to FULL with L = LMAX and the frame counter cleared.

## Timing
- The colour pipeline has 3 ce_pix-qualified stages:
  1. Register inputs and products.
  2. Luma sum and mode select.
  3. Fade multiply.
- Latency: 3 ce_pix pulses from input to R/G/B_out. The sync and blank outputs are delayed identically through a 3-deep shift register.
- With ce_pix=0, all pipeline and sync registers hold.
- `mono` and the fade level are sampled in stage 2 and stage 3 respectively. A change therefore applies to the pixel occupying that stage; no glitch-free frame alignment is provided for `mono`.
- A new L is applied from the clock after the step event. Because steps are taken only on VSync edges, L is constant within a frame.
- Reset values: all colour and timing outputs 0, `fade_level` = LMAX, `fade_busy` 0, FSM in FULL, pipeline cleared.

## Configuration
- `COLOR_MIX_FADE_EN` defined: fade FSM, frame counter and stage-3 multiplier are built as above.
- Not defined:
  - Stage 3 is a plain register, so latency remains 3.
  - `fade_out` is ignored.
  - `fade_level` is tied to LMAX and `fade_busy` to 0.

## Test plan
- DW=8, mono=0, R/G/B=(12,34,56) with ce_pix always 1 → the same values appear exactly 3 clocks later; HSync pulse emerges aligned with them.
- mono=4, input (255,255,255) → (254,254,254). mono=2, input (0,255,0) → Y=182, output (182,137,0).
- ce_pix=1 every 4th clock → the output appears after 3 ce_pix pulses (12 clocks); values hold between pulses.
- FW=4, FADE_DIV=2, hold `fade_out`=1 → L decrements once per 2 VSync edges, reaching 0 after 30 frames; state BLACK, outputs 0, `fade_busy` falls.
- At L=9 in DOWN, deassert `fade_out` → next step gives L=10 (UP); at L=15 → FULL and outputs equal the inputs.
- Assert reset_n=0 asynchronously mid-fade at L=5 → `fade_level`=15 and all outputs 0 immediately. Build without `COLOR_MIX_FADE_EN` → `fade_out` toggling has no effect.
